// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the instruction/data memory port arbiter.
// Optional fetch anti-starvation is enabled with the MEM_ARB_STARVE_EN macro.
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_WAIT_RSP} arb_state_e;

  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} arb_owner_e;

  localparam int unsigned STARVE_LIMIT_DFLT = 4;
  localparam int unsigned STARVE_W          = $clog2(STARVE_LIMIT_DFLT + 1);

  // Counter width able to hold the value `limit` itself.
  function automatic int unsigned starve_w(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the memory port arbiter.
// master = requesters plus memory (environment), slave = the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
);
  logic              i_req_valid_i;
  logic              i_req_ready_o;
  logic [AWIDTH-1:0] i_addr_i;
  logic              i_rsp_valid_o;
  logic [DWIDTH-1:0] i_rsp_data_o;
  logic              d_req_valid_i;
  logic              d_req_ready_o;
  logic              d_we_i;
  logic [AWIDTH-1:0] d_addr_i;
  logic [DWIDTH-1:0] d_wdata_i;
  logic              d_rsp_valid_o;
  logic [DWIDTH-1:0] d_rsp_data_o;
  logic [AWIDTH-1:0] mem_addr_o;
  logic [DWIDTH-1:0] mem_data_o;
  logic              mem_read_en_o;
  logic              mem_write_en_o;
  logic [DWIDTH-1:0] mem_data_i;

  modport master (
    output i_req_valid_i, i_addr_i, d_req_valid_i, d_we_i, d_addr_i, d_wdata_i, mem_data_i,
    input  i_req_ready_o, i_rsp_valid_o, i_rsp_data_o, d_req_ready_o, d_rsp_valid_o,
           d_rsp_data_o, mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o
  );

  modport slave (
    input  i_req_valid_i, i_addr_i, d_req_valid_i, d_we_i, d_addr_i, d_wdata_i, mem_data_i,
    output i_req_ready_o, i_rsp_valid_o, i_rsp_data_o, d_req_ready_o, d_rsp_valid_o,
           d_rsp_data_o, mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o
  );
endinterface

// File: rtl/arb_starve_ctr.sv
// Counts data grants made while fetch is waiting; flags when fetch must be served next.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_i,
  input  logic grant_d,
  input  logic i_valid,
  output logic force_fetch
);
  localparam int unsigned CW = starve_w(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (grant_i) begin
      cnt_d = '0;
    end else if (grant_d) begin
      // Data grants with fetch idle do not count against fetch.
      cnt_d = i_valid ? cnt_q + CW'(1) : '0;
    end
  end

  assign force_fetch = (cnt_q == CW'(STARVE_LIMIT));
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port memory: one transaction every two cycles, data wins.
// Define MEM_ARB_STARVE_EN to bound how long fetch can be held off by back-to-back data traffic.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AWIDTH       = 32,
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DFLT
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  logic       we_q, we_d;
  logic       grant_i, grant_d;
  logic       force_fetch;

`ifdef MEM_ARB_STARVE_EN
  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk         (clk),
    .rst         (rst),
    .grant_i     (grant_i),
    .grant_d     (grant_d),
    .i_valid     (bus.i_req_valid_i),
    .force_fetch (force_fetch)
  );
`else
  logic unused_limit;
  assign unused_limit = ^STARVE_LIMIT;
  assign force_fetch  = 1'b0;
`endif

  // Grants are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (rst && state_q == ARB_IDLE) begin
      if (bus.d_req_valid_i && !(force_fetch && bus.i_req_valid_i)) grant_d = 1'b1;
      else if (bus.i_req_valid_i)                                     grant_i = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_d || grant_i) begin
          state_d = ARB_WAIT_RSP;
          owner_d = grant_d ? OWN_D : OWN_I;
          we_d    = grant_d & bus.d_we_i;
        end
      end
      ARB_WAIT_RSP: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
        we_d    = 1'b0;
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
        we_d    = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.i_req_ready_o  = grant_i;
    bus.d_req_ready_o  = grant_d;
    bus.mem_addr_o     = '0;
    bus.mem_data_o     = '0;
    bus.mem_read_en_o  = 1'b0;
    bus.mem_write_en_o = 1'b0;
    bus.i_rsp_valid_o  = 1'b0;
    bus.i_rsp_data_o   = '0;
    bus.d_rsp_valid_o  = 1'b0;
    bus.d_rsp_data_o   = '0;
    if (grant_d) begin
      bus.mem_addr_o = bus.d_addr_i;
      if (bus.d_we_i) begin
        bus.mem_write_en_o = 1'b1;
        bus.mem_data_o     = bus.d_wdata_i;
      end else begin
        bus.mem_read_en_o = 1'b1;
      end
    end else if (grant_i) begin
      bus.mem_addr_o    = bus.i_addr_i;
      bus.mem_read_en_o = 1'b1;
    end
    if (state_q == ARB_WAIT_RSP) begin
      if (owner_q == OWN_I) begin
        bus.i_rsp_valid_o = 1'b1;
        bus.i_rsp_data_o  = bus.mem_data_i;
      end else if (owner_q == OWN_D) begin
        bus.d_rsp_valid_o = 1'b1;
        bus.d_rsp_data_o  = we_q ? '0 : bus.mem_data_i;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; responses are checked by a scoreboard monitor.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic          is_d;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;
  exp_t exp_q[$];

  mem_port_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  mem_port_arbiter #(
    .AWIDTH       (AW),
    .DWIDTH       (DW),
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req_valid_i = 1'b0;
    bus.i_addr_i      = '0;
    bus.d_req_valid_i = 1'b0;
    bus.d_we_i        = 1'b0;
    bus.d_addr_i      = '0;
    bus.d_wdata_i     = '0;
    bus.mem_data_i    = '0;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, ".i_ready"}, 64'(bus.i_req_ready_o), 64'd0);
    chk({name, ".d_ready"}, 64'(bus.d_req_ready_o), 64'd0);
    chk({name, ".enables"}, 64'({bus.mem_read_en_o, bus.mem_write_en_o}), 64'd0);
    chk({name, ".addr"}, 64'(bus.mem_addr_o), 64'd0);
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.i_rsp_valid_o && bus.d_rsp_valid_o) begin
      chk("mon.both_rsp", 64'd1, 64'd0);
    end else if (bus.i_rsp_valid_o || bus.d_rsp_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("mon.unexpected_rsp", {32'd0, bus.i_rsp_valid_o ? bus.i_rsp_data_o
                                                            : bus.d_rsp_data_o}, 64'hFFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon.rsp_port", 64'(bus.d_rsp_valid_o), 64'(e.is_d));
        chk("mon.rsp_data", 64'(bus.d_rsp_valid_o ? bus.d_rsp_data_o : bus.i_rsp_data_o),
            64'(e.data));
        if (bus.d_rsp_valid_o) chk("mon.i_idle_data", 64'(bus.i_rsp_data_o), 64'd0);
        else                   chk("mon.d_idle_data", 64'(bus.d_rsp_data_o), 64'd0);
      end
    end
  end

  initial begin
    logic [7:0] seq_got;
    logic [7:0] seq_exp;
    idle_inputs();

    // 1: reset holds everything at 0 even with requests pending
    bus.i_req_valid_i = 1'b1;
    bus.i_addr_i      = 32'h0100_0000;
    bus.d_req_valid_i = 1'b1;
    bus.d_addr_i      = 32'h0100_0040;
    tick();
    tick();
    chk_quiet("rst_hold");
    chk("rst_hold.rsp", 64'({bus.i_rsp_valid_o, bus.d_rsp_valid_o}), 64'd0);
    idle_inputs();
    rst = 1'b1;
    tick();
    chk_quiet("idle0");
    tick();
    chk_quiet("idle1");

    // 2: fetch only
    bus.i_req_valid_i = 1'b1;
    bus.i_addr_i      = 32'h0100_0000;
    @(negedge clk);
    chk("fetch.i_ready", 64'(bus.i_req_ready_o), 64'd1);
    chk("fetch.read_en", 64'(bus.mem_read_en_o), 64'd1);
    chk("fetch.write_en", 64'(bus.mem_write_en_o), 64'd0);
    chk("fetch.addr", 64'(bus.mem_addr_o), 64'h0100_0000);
    exp_q.push_back('{is_d: 1'b0, data: 32'h0000_0013});
    tick();
    bus.i_req_valid_i = 1'b0;
    bus.mem_data_i    = 32'h0000_0013;
    @(negedge clk);
    chk("fetch.c1_ready", 64'(bus.i_req_ready_o), 64'd0);
    tick();

    // 3: fetch and load together: data first, then fetch
    bus.i_req_valid_i = 1'b1;
    bus.i_addr_i      = 32'h0100_0004;
    bus.d_req_valid_i = 1'b1;
    bus.d_we_i        = 1'b0;
    bus.d_addr_i      = 32'h0100_0080;
    @(negedge clk);
    chk("tie.d_ready", 64'(bus.d_req_ready_o), 64'd1);
    chk("tie.i_ready", 64'(bus.i_req_ready_o), 64'd0);
    chk("tie.addr", 64'(bus.mem_addr_o), 64'h0100_0080);
    chk("tie.read_en", 64'(bus.mem_read_en_o), 64'd1);
    exp_q.push_back('{is_d: 1'b1, data: 32'hA5A5_0001});
    tick();
    bus.d_req_valid_i = 1'b0;
    bus.mem_data_i    = 32'hA5A5_0001;
    @(negedge clk);
    chk_quiet("tie.c1");
    tick();
    @(negedge clk);
    chk("tie.c2_i_ready", 64'(bus.i_req_ready_o), 64'd1);
    chk("tie.c2_addr", 64'(bus.mem_addr_o), 64'h0100_0004);
    exp_q.push_back('{is_d: 1'b0, data: 32'h0000_0093});
    tick();
    bus.i_req_valid_i = 1'b0;
    bus.mem_data_i    = 32'h0000_0093;
    @(negedge clk);
    chk_quiet("tie.c3");
    tick();

    // 4: store
    bus.d_req_valid_i = 1'b1;
    bus.d_we_i        = 1'b1;
    bus.d_addr_i      = 32'h0100_0040;
    bus.d_wdata_i     = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("st.write_en", 64'(bus.mem_write_en_o), 64'd1);
    chk("st.read_en", 64'(bus.mem_read_en_o), 64'd0);
    chk("st.wdata", 64'(bus.mem_data_o), 64'hDEAD_BEEF);
    chk("st.addr", 64'(bus.mem_addr_o), 64'h0100_0040);
    exp_q.push_back('{is_d: 1'b1, data: 32'h0});
    tick();
    idle_inputs();
    bus.mem_data_i = 32'h1234_5678;
    tick();

    // 5: continuous traffic from both ports
`ifdef MEM_ARB_STARVE_EN
    seq_exp = 8'b0010_1111;
`else
    seq_exp = 8'b0011_1111;
`endif
    seq_got = '0;
    bus.i_req_valid_i = 1'b1;
    bus.i_addr_i      = 32'h0100_0008;
    bus.d_req_valid_i = 1'b1;
    bus.d_addr_i      = 32'h0100_00C0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seq_got[k] = bus.d_req_ready_o;
      chk("burst.one_grant", 64'(bus.d_req_ready_o ^ bus.i_req_ready_o), 64'd1);
      exp_q.push_back('{is_d: bus.d_req_ready_o, data: 32'h100 + 32'(k)});
      tick();
      bus.mem_data_i = 32'h100 + 32'(k);
      @(negedge clk);
      chk_quiet("burst.wait");
      tick();
    end
    chk("burst.grant_seq", 64'(seq_got), 64'(seq_exp));
    idle_inputs();
    tick();

    // 6: reset during the response cycle of a load drops the response
    bus.d_req_valid_i = 1'b1;
    bus.d_addr_i      = 32'h0100_0100;
    @(negedge clk);
    chk("rst6.d_ready", 64'(bus.d_req_ready_o), 64'd1);
    tick();
    bus.d_req_valid_i = 1'b0;
    bus.mem_data_i    = 32'hCAFE_0000;
    rst = 1'b0;
    #1;
    chk("rst6.async_rsp", 64'(bus.d_rsp_valid_o), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    bus.i_req_valid_i = 1'b1;
    bus.i_addr_i      = 32'h0100_0010;
    @(negedge clk);
    chk("rst6.new_grant", 64'(bus.i_req_ready_o), 64'd1);
    exp_q.push_back('{is_d: 1'b0, data: 32'h0000_0073});
    tick();
    bus.i_req_valid_i = 1'b0;
    bus.mem_data_i    = 32'h0000_0073;
    tick();
    tick();

    chk("sb.drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish, expected finish before 20000");
    $fatal(1, "timeout");
  end
endmodule
